push_crc_engine: RTL and testbench

PUSH_CRC_ENGINE -- requirements
Module: push_crc_engine

---
 rtl/push_crc_engine.sv | 143 ++++++++++++++
 tb/tb_push_crc_engine.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/push_crc_engine.sv
// Two-segment push CRC-16 engine: accepts len_a then len_b bytes after start,
// folding each accepted byte MSB-first into a CRC register, then publishes the result.
module push_crc_engine #(
    parameter logic [15:0] POLY   = 16'h1021,
    parameter logic [15:0] INIT   = 16'hFFFF,
    parameter logic [15:0] XOROUT = 16'h0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [3:0]  len_a,
    input  logic [3:0]  len_b,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        push_a_done,
    output logic        push_b_done,
    output logic        crc_done,
    output logic [15:0] crc_out,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StPushA, StPushB, StCrc} state_e;

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [3:0]  len_a_q, len_a_d;
    logic [3:0]  len_b_q, len_b_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] crc_out_q, crc_out_d;
    logic        push_a_done_q, push_a_done_d;
    logic        push_b_done_q, push_b_done_d;
    logic        crc_done_q, crc_done_d;

    logic        xfer;
    logic [3:0]  count_inc;

    function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
        return c;
    endfunction

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StPushA: in_ready = (count_q < len_a_q);
            StPushB: in_ready = (count_q < len_b_q);
            default: in_ready = 1'b0;
        endcase
    end

    assign xfer      = in_valid & in_ready;
    assign count_inc = count_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        len_a_d       = len_a_q;
        len_b_d       = len_b_q;
        crc_d         = crc_q;
        crc_out_d     = crc_out_q;
        push_a_done_d = 1'b0;
        push_b_done_d = 1'b0;
        crc_done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StPushA;
                    len_a_d = len_a;
                    len_b_d = len_b;
                    crc_d   = INIT;
                    count_d = 4'd0;
                end
            end
            StPushA: begin
                if (xfer) begin
                    crc_d   = crc_byte(crc_q, in_data);
                    count_d = count_inc;
                end
                // Leave on the edge of the final transfer, or at once for an empty segment.
                if ((count_q == len_a_q) || (xfer && (count_inc == len_a_q))) begin
                    state_d       = StPushB;
                    count_d       = 4'd0;
                    push_a_done_d = 1'b1;
                end
            end
            StPushB: begin
                if (xfer) begin
                    crc_d   = crc_byte(crc_q, in_data);
                    count_d = count_inc;
                end
                if ((count_q == len_b_q) || (xfer && (count_inc == len_b_q))) begin
                    state_d       = StCrc;
                    push_b_done_d = 1'b1;
                end
            end
            StCrc: begin
                state_d    = StIdle;
                crc_out_d  = crc_q ^ XOROUT;
                crc_done_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            count_q       <= 4'd0;
            len_a_q       <= 4'd0;
            len_b_q       <= 4'd0;
            crc_q         <= INIT;
            crc_out_q     <= 16'h0000;
            push_a_done_q <= 1'b0;
            push_b_done_q <= 1'b0;
            crc_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            len_a_q       <= len_a_d;
            len_b_q       <= len_b_d;
            crc_q         <= crc_d;
            crc_out_q     <= crc_out_d;
            push_a_done_q <= push_a_done_d;
            push_b_done_q <= push_b_done_d;
            crc_done_q    <= crc_done_d;
        end
    end

    assign push_a_done = push_a_done_q;
    assign push_b_done = push_b_done_q;
    assign crc_done    = crc_done_q;
    assign crc_out     = crc_out_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_push_crc_engine.sv
// Directed bench for push_crc_engine: table of frames plus hand-written reset and
// back-to-back start sequences.
module tb_push_crc_engine;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  len_a = 4'd0;
    logic [3:0]  len_b = 4'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        push_a_done;
    logic        push_b_done;
    logic        crc_done;
    logic [15:0] crc_out;
    logic        busy;

    int checks = 0;
    int failures = 0;

    push_crc_engine dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .len_a       (len_a),
        .len_b       (len_b),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .push_a_done (push_a_done),
        .push_b_done (push_b_done),
        .crc_done    (crc_done),
        .crc_out     (crc_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  la;
        logic [3:0]  lb;
        bit          gap;   // in_valid toggles every cycle
        bit          poke;  // pulse start with other lengths during B
        int          mode;  // 0: "123456789...", 1: zero bytes
        logic [15:0] crc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_frame(input int id, input vec_t v);
        int n;
        int idx;
        int t;
        int t_a;
        int t_b;
        int t_c;
        int last_a;
        int last_b;
        int rdy_cnt;
        int exp_a;
        int exp_b;
        bit poked;
        bit xfer;
        logic [15:0] got;
        logic busy_at_done;
        string tag;
        n = int'(v.la) + int'(v.lb);
        idx = 0; t_a = -1; t_b = -1; t_c = -1; last_a = 0; last_b = 0;
        rdy_cnt = 0; poked = 1'b0; got = 16'h0; busy_at_done = 1'b1;
        tag = $sformatf("v%0d", id);

        @(negedge clk);
        start = 1'b1; len_a = v.la; len_b = v.lb; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        t = 1;
        while (t < 200) begin
            if (push_a_done && t_a < 0) t_a = t;
            if (push_b_done && t_b < 0) t_b = t;
            if (crc_done) begin
                t_c = t; got = crc_out; busy_at_done = busy;
                break;
            end
            if (in_ready) rdy_cnt++;
            in_valid = (idx < n) && (!v.gap || (t % 2 == 1));
            in_data  = (v.mode == 0) ? 8'(8'h31 + idx) : 8'h00;
            if (v.poke && !poked && idx > int'(v.la) && idx < n - 1) begin
                start = 1'b1; len_a = 4'd15; len_b = 4'd15; poked = 1'b1;
            end
            xfer = in_valid && in_ready;
            @(posedge clk);
            if (xfer) begin
                idx++;
                if (idx == int'(v.la)) last_a = t;
                if (idx == n) last_b = t;
            end
            t++;
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;

        exp_a = (v.la == 4'd0) ? 2 : last_a + 1;
        exp_b = (v.lb == 4'd0) ? exp_a + 1 : last_b + 1;
        chk({tag, "_crc_done_seen"}, 32'(t_c > 0), 32'd1);
        chk({tag, "_bytes_taken"}, 32'(idx), 32'(n));
        chk({tag, "_push_a_cycle"}, 32'(t_a), 32'(exp_a));
        chk({tag, "_push_b_cycle"}, 32'(t_b), 32'(exp_b));
        chk({tag, "_crc_done_cycle"}, 32'(t_c), 32'(exp_b + 1));
        chk({tag, "_crc_out"}, 32'(got), 32'(v.crc));
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        if (n == 0) chk({tag, "_ready_never"}, 32'(rdy_cnt), 32'd0);
        if (v.poke) chk({tag, "_poke_done"}, 32'(poked), 32'd1);
    endtask

    initial begin
        int bad;
        logic exp_busy [1:8];
        logic exp_done [1:8];
        vecs[0] = '{la: 4'd4, lb: 4'd5, gap: 1'b0, poke: 1'b0, mode: 0, crc: 16'h29B1};
        vecs[1] = '{la: 4'd4, lb: 4'd5, gap: 1'b1, poke: 1'b0, mode: 0, crc: 16'h29B1};
        vecs[2] = '{la: 4'd9, lb: 4'd0, gap: 1'b0, poke: 1'b0, mode: 0, crc: 16'h29B1};
        vecs[3] = '{la: 4'd0, lb: 4'd9, gap: 1'b1, poke: 1'b0, mode: 0, crc: 16'h29B1};
        vecs[4] = '{la: 4'd0, lb: 4'd0, gap: 1'b0, poke: 1'b0, mode: 0, crc: 16'hFFFF};
        vecs[5] = '{la: 4'd1, lb: 4'd0, gap: 1'b0, poke: 1'b0, mode: 1, crc: 16'hE1F0};
        vecs[6] = '{la: 4'd0, lb: 4'd1, gap: 1'b1, poke: 1'b0, mode: 1, crc: 16'hE1F0};
        vecs[7] = '{la: 4'd2, lb: 4'd7, gap: 1'b1, poke: 1'b0, mode: 0, crc: 16'h29B1};
        vecs[8] = '{la: 4'd4, lb: 4'd5, gap: 1'b0, poke: 1'b1, mode: 0, crc: 16'h29B1};

        // Reset state
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_push_a_done", 32'(push_a_done), 32'd0);
        chk("rst_push_b_done", 32'(push_b_done), 32'd0);
        chk("rst_crc_done", 32'(crc_done), 32'd0);
        chk("rst_crc_out", 32'(crc_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 9; i++) run_frame(i, vecs[i]);

        // Reset after two A bytes discards the frame
        @(negedge clk);
        start = 1'b1; len_a = 4'd4; len_b = 4'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h31;
        @(posedge clk);
        @(negedge clk);
        in_data = 8'h32;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_crc_out", 32'(crc_out), 32'd0);
        chk("midrst_pulses", 32'({push_a_done, push_b_done, crc_done}), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || push_a_done || push_b_done || crc_done || in_ready) bad++;
        end
        chk("midrst_quiet_after_release", 32'(bad), 32'd0);
        run_frame(20, vecs[0]);

        // start held high through crc_done: back-to-back empty frames
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        start = 1'b1; len_a = 4'd0; len_b = 4'd0;
        @(posedge clk);
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (t == 1) chk("held_crc_out_kept", 32'(crc_out), 32'h29B1);
            chk($sformatf("held_busy_c%0d", t), 32'(busy), 32'(exp_busy[t]));
            chk($sformatf("held_crc_done_c%0d", t), 32'(crc_done), 32'(exp_done[t]));
            if (exp_done[t]) chk($sformatf("held_crc_out_c%0d", t), 32'(crc_out), 32'hFFFF);
            if (t == 5) start = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
